// File: rtl/irq_controller.sv
// Interrupt aggregator for the 6502 core: synchronises up to 8 IRQ sources and one NMI,
// tracks per-source edge/level pending state, masks it onto irqb and stretches NMI events on nmib.
module irq_controller #(
  parameter int NUM_SRC     = 8,
  parameter int NMI_PULSE   = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               chip_en,
  input  logic               wrt_en,
  input  logic [1:0]         register_select,
  input  logic [7:0]         data_in,
  output logic [7:0]         data_out,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               nmi_src,
  output logic               irqb,
  output logic               nmib
);

  localparam int SW    = NUM_SRC + 1;
  localparam int CNT_W = (NMI_PULSE < 2) ? 1 : $clog2(NMI_PULSE + 1);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(NMI_PULSE);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(1'b0);

  typedef enum logic {
    IDLE  = 1'b0,
    PULSE = 1'b1
  } nmi_state_t;

  // NMI rides in the top bit of the synchroniser bus alongside the IRQ sources
  logic [SW-1:0]      sync_r [SYNC_STAGES];
  logic [SW-1:0]      sync_d_r;
  logic [SW-1:0]      sync_s;
  logic [SW-1:0]      rise_s;
  logic [NUM_SRC-1:0] pending_r;
  logic [NUM_SRC-1:0] enable_r;
  logic [NUM_SRC-1:0] mode_r;
  logic [NUM_SRC-1:0] pending_next_s;
  logic [NUM_SRC-1:0] active_s;
  logic               wr_s;
  logic               clr_wr_s;
  logic               en_wr_s;
  logic               mode_wr_s;
  logic               sw_nmi_s;
  logic               nmi_trig_s;
  logic [2:0]         vec_idx_s;
  logic               irqb_r;
  nmi_state_t         state_r;
  nmi_state_t         state_next_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   cnt_next_s;
  logic               nmib_r;
  logic               nmib_next_s;

  function automatic logic [7:0] pad8(input logic [NUM_SRC-1:0] v);
    pad8 = 8'h00;
    pad8[NUM_SRC-1:0] = v;
  endfunction

  assign sync_s     = sync_r[SYNC_STAGES-1];
  assign rise_s     = sync_s & ~sync_d_r;
  assign active_s   = pending_r & enable_r;
  assign wr_s       = chip_en & wrt_en;
  assign nmi_trig_s = rise_s[NUM_SRC] | sw_nmi_s;
  assign irqb       = irqb_r;
  assign nmib       = nmib_r;

  // Input synchroniser chain plus one-cycle delayed copy for edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j < SYNC_STAGES; j++) sync_r[j] <= {SW{1'b0}};
      sync_d_r <= {SW{1'b0}};
    end else begin
      sync_r[0] <= {nmi_src, irq_src};
      for (int j = 1; j < SYNC_STAGES; j++) sync_r[j] <= sync_r[j-1];
      sync_d_r <= sync_s;
    end
  end

  // Register write decode
  always_comb begin
    clr_wr_s  = 1'b0;
    en_wr_s   = 1'b0;
    mode_wr_s = 1'b0;
    sw_nmi_s  = 1'b0;
    if (wr_s) begin
      case (register_select)
        2'd0:    clr_wr_s  = 1'b1;
        2'd1:    en_wr_s   = 1'b1;
        2'd2:    mode_wr_s = 1'b1;
        2'd3:    sw_nmi_s  = data_in[0];
        default: clr_wr_s  = 1'b0;
      endcase
    end else begin
      clr_wr_s = 1'b0;
    end
  end

  // Per-source pending update; in edge mode a new edge beats a simultaneous write-clear
  always_comb begin
    pending_next_s = pending_r;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!mode_r[i]) begin
        pending_next_s[i] = sync_s[i];
      end else if (rise_s[i]) begin
        pending_next_s[i] = 1'b1;
      end else if (clr_wr_s && data_in[i]) begin
        pending_next_s[i] = 1'b0;
      end else begin
        pending_next_s[i] = pending_r[i];
      end
    end
  end

  // Pending, enable, mode and the registered IRQ line
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_r <= {NUM_SRC{1'b0}};
      enable_r  <= {NUM_SRC{1'b0}};
      mode_r    <= {NUM_SRC{1'b0}};
      irqb_r    <= 1'b1;
    end else begin
      pending_r <= pending_next_s;
      if (en_wr_s) enable_r <= data_in[NUM_SRC-1:0];
      if (mode_wr_s) mode_r <= data_in[NUM_SRC-1:0];
      irqb_r <= ~|active_s;
    end
  end

  // Lowest active index: scanning downward lets the last hit win
  always_comb begin
    vec_idx_s = 3'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (active_s[i]) begin
        vec_idx_s = 3'(i);
      end else begin
        vec_idx_s = vec_idx_s;
      end
    end
  end

  // Side-effect-free read mux
  always_comb begin
    data_out = 8'h00;
    if (chip_en && !wrt_en) begin
      case (register_select)
        2'd0:    data_out = pad8(pending_r);
        2'd1:    data_out = pad8(enable_r);
        2'd2:    data_out = pad8(mode_r);
        2'd3:    data_out = {|active_s, 4'b0000, vec_idx_s};
        default: data_out = 8'h00;
      endcase
    end else begin
      data_out = 8'h00;
    end
  end

  // NMI pulse state, counter and output register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      nmib_r  <= 1'b1;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      nmib_r  <= nmib_next_s;
    end
  end

  // NMI next state: triggers seen while pulsing are dropped
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    nmib_next_s  = nmib_r;
    case (state_r)
      IDLE: begin
        if (nmi_trig_s) begin
          state_next_s = PULSE;
          cnt_next_s   = PULSE_LOAD;
          nmib_next_s  = 1'b0;
        end else begin
          nmib_next_s  = 1'b1;
        end
      end
      PULSE: begin
        if (cnt_r == CNT_ONE) begin
          state_next_s = IDLE;
          cnt_next_s   = CNT_ZERO;
          nmib_next_s  = 1'b1;
        end else begin
          cnt_next_s   = cnt_r - CNT_ONE;
          nmib_next_s  = 1'b0;
        end
      end
      default: begin
        state_next_s = IDLE;
        cnt_next_s   = CNT_ZERO;
        nmib_next_s  = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: input-history reference model compared every cycle,
// plus directed sequences with hand-computed expectations.
module tb_irq_controller;

  localparam int NUM_SRC   = 8;
  localparam int NMI_PULSE = 3;
  localparam int SYNC      = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       chip_en;
  logic       wrt_en;
  logic [1:0] register_select;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic [7:0] irq_src;
  logic       nmi_src;
  logic       irqb;
  logic       nmib;

  int n_err = 0;
  int n_chk = 0;

  // Reference model: raw input history, architectural registers, NMI low-cycles remaining
  logic [8:0] hist [0:SYNC];
  logic [7:0] m_pend;
  logic [7:0] m_en;
  logic [7:0] m_mode;
  logic       m_irqb;
  int         m_rem;

  always #5 clk = ~clk;

  irq_controller #(.NUM_SRC(NUM_SRC), .NMI_PULSE(NMI_PULSE), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset(reset), .chip_en(chip_en), .wrt_en(wrt_en),
    .register_select(register_select), .data_in(data_in), .data_out(data_out),
    .irq_src(irq_src), .nmi_src(nmi_src), .irqb(irqb), .nmib(nmib)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_vec(input logic [7:0] pe);
    int k;
    k = 0;
    if (pe == 8'h00) return 8'h00;
    while (!pe[k]) k++;
    return 8'h80 | 8'(k);
  endfunction

  function automatic logic [7:0] m_read(input logic [1:0] sel);
    case (sel)
      2'd0:    return m_pend;
      2'd1:    return m_en;
      2'd2:    return m_mode;
      default: return m_vec(m_pend & m_en);
    endcase
  endfunction

  // Advance the model across one rising edge using the inputs held before it
  task automatic model_step();
    logic [8:0] s;
    logic [8:0] sd;
    logic [7:0] np;
    logic       wr;
    logic       trig;
    if (!reset) begin
      for (int j = 0; j <= SYNC; j++) hist[j] = 9'h000;
      m_pend = 8'h00; m_en = 8'h00; m_mode = 8'h00; m_irqb = 1'b1; m_rem = 0;
    end else begin
      s  = hist[SYNC-1];
      sd = hist[SYNC];
      wr = chip_en && wrt_en;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (!m_mode[i])                                   np[i] = s[i];
        else if (s[i] && !sd[i])                          np[i] = 1'b1;
        else if (wr && register_select == 2'd0 && data_in[i]) np[i] = 1'b0;
        else                                              np[i] = m_pend[i];
      end
      m_irqb = ((m_pend & m_en) == 8'h00);
      trig = (s[8] && !sd[8]) || (wr && register_select == 2'd3 && data_in[0]);
      if (m_rem > 0) m_rem--;
      else if (trig) m_rem = NMI_PULSE;
      m_pend = np;
      if (wr && register_select == 2'd1) m_en = data_in;
      if (wr && register_select == 2'd2) m_mode = data_in;
      for (int j = SYNC; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = {nmi_src, irq_src};
    end
  endtask

  // Per-cycle comparison against the model, sampled 1 time unit after the edge
  always @(posedge clk) begin
    model_step();
    #1;
    chk("cyc_irqb", {7'd0, irqb}, {7'd0, m_irqb});
    chk("cyc_nmib", {7'd0, nmib}, (m_rem == 0) ? 8'h01 : 8'h00);
    chk("cyc_data_out", data_out, (chip_en && !wrt_en) ? m_read(register_select) : 8'h00);
  end

  task automatic bus(input logic ce, input logic we, input logic [1:0] sel, input logic [7:0] d);
    @(negedge clk);
    chip_en = ce; wrt_en = we; register_select = sel; data_in = d;
  endtask

  task automatic nop();
    bus(1'b0, 1'b0, 2'd0, 8'h00);
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) nop();
  endtask

  task automatic wr(input logic [1:0] sel, input logic [7:0] d);
    bus(1'b1, 1'b1, sel, d);
  endtask

  task automatic rd(input string name, input logic [1:0] sel, input logic [7:0] exp);
    bus(1'b1, 1'b0, sel, 8'h00);
    #1;
    chk(name, data_out, exp);
  endtask

  task automatic chk_irqb(input string name, input logic exp);
    #1;
    chk(name, {7'd0, irqb}, {7'd0, exp});
  endtask

  task automatic chk_nmib(input string name, input logic exp);
    #1;
    chk(name, {7'd0, nmib}, {7'd0, exp});
  endtask

  initial begin
    reset = 1'b0; chip_en = 1'b0; wrt_en = 1'b0; register_select = 2'd0;
    data_in = 8'h00; irq_src = 8'h00; nmi_src = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    chk_irqb("rst_irqb", 1'b1);
    chk_nmib("rst_nmib", 1'b1);
    rd("rst_reg0", 2'd0, 8'h00);
    rd("rst_reg1", 2'd1, 8'h00);
    rd("rst_reg2", 2'd2, 8'h00);
    rd("rst_reg3", 2'd3, 8'h00);

    // Edge-mode source 0, one-cycle pulse
    wr(2'd1, 8'h05); wr(2'd2, 8'h01);
    nop(); irq_src = 8'h01;
    nop(); irq_src = 8'h00;
    nop();
    nop(); chk_irqb("edge_irqb_k2", 1'b1);
    nop(); chk_irqb("edge_irqb_k3", 1'b0);
    rd("edge_reg0", 2'd0, 8'h01);
    rd("edge_reg3", 2'd3, 8'h80);
    wr(2'd0, 8'h01);
    nop(); chk_irqb("clr_irqb_w", 1'b0);
    nop(); chk_irqb("clr_irqb_w1", 1'b1);

    // Level-mode source 2
    wr(2'd2, 8'h00); wr(2'd1, 8'h04);
    nop(); irq_src = 8'h04;
    nops(4);
    rd("lvl_reg3", 2'd3, 8'h82);
    chk_irqb("lvl_irqb", 1'b0);
    wr(2'd0, 8'h04); nop();
    rd("lvl_noclr_reg0", 2'd0, 8'h04);
    nop(); irq_src = 8'h00;
    nops(3);
    rd("lvl_drop_reg0", 2'd0, 8'h00);
    chk_irqb("lvl_drop_irqb", 1'b1);

    // Vector priority
    wr(2'd1, 8'hFF); irq_src = 8'h28;
    nops(4);
    rd("pri_reg3_ff", 2'd3, 8'h83);
    wr(2'd1, 8'hF7);
    rd("pri_reg3_f7", 2'd3, 8'h85);
    irq_src = 8'h00;
    nops(4);

    // Edge set colliding with write-1 clear on source 1
    wr(2'd2, 8'h02); wr(2'd1, 8'h02);
    nop(); irq_src = 8'h02;
    nop(); irq_src = 8'h00;
    nops(4);
    chk_irqb("col_pre_irqb", 1'b0);
    nop(); irq_src = 8'h02;
    nop();
    wr(2'd0, 8'h02);
    rd("col_reg0", 2'd0, 8'h02);
    chk_irqb("col_irqb", 1'b0);
    nop(); chk_irqb("col_irqb_next", 1'b0);
    irq_src = 8'h00;
    wr(2'd0, 8'h02);
    nops(3);
    rd("col_clr_reg0", 2'd0, 8'h00);

    // Hardware NMI with a second edge inside the pulse
    nop(); nmi_src = 1'b1;
    nop(); nmi_src = 1'b0;
    nop(); nmi_src = 1'b1;
    nop(); chk_nmib("nmi_p1", 1'b0);
    nop(); chk_nmib("nmi_p2", 1'b0);
    nop(); chk_nmib("nmi_p3", 1'b0);
    nop(); chk_nmib("nmi_end", 1'b1);
    nop(); chk_nmib("nmi_noext", 1'b1);
    nmi_src = 1'b0;
    nops(3);

    // Software NMI
    wr(2'd3, 8'h01);
    nop(); chk_nmib("sw_p1", 1'b0);
    nop(); chk_nmib("sw_p2", 1'b0);
    nop(); chk_nmib("sw_p3", 1'b0);
    nop(); chk_nmib("sw_end", 1'b1);

    // Hardware and software trigger on the same edge
    nop(); nmi_src = 1'b1;
    nop();
    wr(2'd3, 8'h01);
    nop(); chk_nmib("both_p1", 1'b0);
    nop(); chk_nmib("both_p2", 1'b0);
    nop(); chk_nmib("both_p3", 1'b0);
    nop(); chk_nmib("both_end", 1'b1);
    nop(); chk_nmib("both_single", 1'b1);
    nmi_src = 1'b0;
    nops(3);

    // Reset asserted mid-pulse
    wr(2'd3, 8'h01);
    nop(); chk_nmib("rstmid_pre", 1'b0);
    #2 reset = 1'b0;
    chk_nmib("rstmid_nmib", 1'b1);
    nops(2);
    reset = 1'b1;
    nops(2);
    rd("post_rst_reg1", 2'd1, 8'h00);
    rd("post_rst_reg2", 2'd2, 8'h00);
    nops(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
